// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op/state encodings and operand-signedness helpers for muldiv_unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} muldiv_state_e;

    function automatic logic is_div(muldiv_op_e op);
        return op[2];
    endfunction

    function automatic logic rs1_signed(muldiv_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic rs2_signed(muldiv_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/response bus between the EX stage (master) and muldiv_unit (slave)
interface muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    import muldiv_pkg::*;

    logic             flush;
    logic             req_valid;
    logic             req_ready;
    muldiv_op_e       op;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [TAG_W-1:0] tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] rsp_tag;
    logic             dbz;

    modport master (
        output flush, req_valid, op, rs1, rs2, tag, rsp_ready,
        input  req_ready, rsp_valid, result, rsp_tag, dbz
    );

    modport slave (
        input  flush, req_valid, op, rs1, rs2, tag, rsp_ready,
        output req_ready, rsp_valid, result, rsp_tag, dbz
    );

endinterface

// File: rtl/muldiv_lzc.sv
// muldiv_lzc: combinational leading-zero count (returns XLEN for an all-zero input)
module muldiv_lzc #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]       x,
    output logic [$clog2(XLEN):0] cnt
);
    localparam int CW = $clog2(XLEN) + 1;

    always_comb begin
        cnt = CW'(XLEN);
        for (int i = 0; i < XLEN; i++)
            if (x[i]) cnt = CW'(XLEN - 1 - i);
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit with tagged, flushable results.
// Defining MULDIV_EARLY_OUT_EN skips the dividend's leading zeros in the divide loop.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 2,
    parameter int TAG_W    = 5
) (
    input logic     clk,
    input logic     rst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = XLEN + MUL_BITS;

    muldiv_state_e     state;
    muldiv_op_e        op_q;
    logic [CW-1:0]     cnt;
    logic              neg, rneg, dbz_q, n1, n2, dbz_in, ovf_in;
    logic [XLEN-1:0]   a, b, quo, rem, res_q, mag1, mag2, spec_res;
    logic [XLEN-1:0]   rem_nx, quo_nx, div_out, mul_out;
    logic [TAG_W-1:0]  tag_q;
    logic [2*XLEN-1:0] prod, prod_nx, mul_res;
    logic [PW-1:0]     psum;
    logic [XLEN:0]     trial;

`ifdef MULDIV_EARLY_OUT_EN
    logic [CW-1:0] lz;
    muldiv_lzc #(.XLEN(XLEN)) u_lzc (.x(mag1), .cnt(lz));
`endif

    always_comb begin
        n1       = rs1_signed(bus.op) && bus.rs1[XLEN-1];
        n2       = rs2_signed(bus.op) && bus.rs2[XLEN-1];
        mag1     = n1 ? -bus.rs1 : bus.rs1;
        mag2     = n2 ? -bus.rs2 : bus.rs2;
        dbz_in   = is_div(bus.op) && bus.rs2 == '0;
        ovf_in   = bus.op inside {OP_DIV, OP_REM} && bus.rs1 == {1'b1, {(XLEN-1){1'b0}}} && &bus.rs2;
        // also yields 0 for a zero dividend, which is rs1 itself
        spec_res = dbz_in ? (bus.op[1] ? bus.rs1 : '1) : (bus.op[1] ? '0 : bus.rs1);
    end

    always_comb begin
        // high half accumulates partial products while the multiplier shifts out of the low half
        psum    = PW'(prod[2*XLEN-1:XLEN]) + PW'(a) * PW'(prod[MUL_BITS-1:0]);
        prod_nx = {psum, prod[XLEN-1:MUL_BITS]};
        mul_res = neg ? -prod_nx : prod_nx;
        mul_out = op_q == OP_MUL ? mul_res[XLEN-1:0] : mul_res[2*XLEN-1:XLEN];
        trial   = {rem, quo[XLEN-1]} - {1'b0, b};
        rem_nx  = trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
        quo_nx  = {quo[XLEN-2:0], ~trial[XLEN]};
        div_out = op_q[1] ? (rneg ? -rem_nx : rem_nx) : (neg ? -quo_nx : quo_nx);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            op_q  <= OP_MUL;
            cnt   <= '0;
            neg   <= 1'b0;
            rneg  <= 1'b0;
            a     <= '0;
            b     <= '0;
            quo   <= '0;
            rem   <= '0;
            prod  <= '0;
            res_q <= '0;
            tag_q <= '0;
            dbz_q <= 1'b0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (bus.req_valid) begin
                    op_q  <= bus.op;
                    neg   <= n1 ^ n2;
                    rneg  <= n1;
                    a     <= mag1;
                    b     <= mag2;
                    prod  <= {{XLEN{1'b0}}, mag2};
                    rem   <= '0;
                    tag_q <= bus.tag;
                    dbz_q <= dbz_in;
                    res_q <= spec_res;
                    if (dbz_in || ovf_in) state <= ST_DONE;
`ifdef MULDIV_EARLY_OUT_EN
                    else if (is_div(bus.op) && mag1 == '0) state <= ST_DONE;
                    else if (is_div(bus.op)) begin
                        state <= ST_DIV;
                        cnt   <= CW'(XLEN) - lz;
                        quo   <= mag1 << lz;
                    end
`else
                    else if (is_div(bus.op)) begin
                        state <= ST_DIV;
                        cnt   <= CW'(XLEN);
                        quo   <= mag1;
                    end
`endif
                    else begin
                        state <= ST_MUL;
                        cnt   <= CW'(XLEN / MUL_BITS);
                    end
                end
                ST_MUL: begin
                    cnt  <= cnt - CW'(1);
                    prod <= prod_nx;
                    if (cnt == CW'(1)) begin
                        state <= ST_DONE;
                        res_q <= mul_out;
                    end
                end
                ST_DIV: begin
                    cnt <= cnt - CW'(1);
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (cnt == CW'(1)) begin
                        state <= ST_DONE;
                        res_q <= div_out;
                    end
                end
                ST_DONE: if (bus.rsp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready = state == ST_IDLE;
    assign bus.rsp_valid = state == ST_DONE;
    assign bus.result    = res_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized and directed checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] last_res;
    logic [4:0]  last_tag;
    logic        last_dbz;
    int          last_lat;

    muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    muldiv_unit #(.XLEN(XLEN), .MUL_BITS(2), .TAG_W(TAG_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lead_zeros(input logic [31:0] v);
        for (int i = 31; i >= 0; i--)
            if (v[i]) return 31 - i;
        return 32;
    endfunction

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        logic ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (op)
            3'd0: p = sx * sy;
            3'd1: p = sx * sy;
            3'd2: p = sx * uy;
            3'd3: p = ux * uy;
            3'd4: p = (y == 0) ? -64'sd1 : ovf ? sx : sx / sy;
            3'd5: p = (y == 0) ? -64'sd1 : ux / uy;
            3'd6: p = (y == 0) ? sx : ovf ? 64'sd0 : sx % sy;
            default: p = (y == 0) ? ux : ux % uy;
        endcase
        if (op == 3'd1 || op == 3'd2 || op == 3'd3) return p[63:32];
        return p[31:0];
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        if (!op[2]) return 17;
        if (y == 0 || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`ifdef MULDIV_EARLY_OUT_EN
        begin
            logic [31:0] mag;
            mag = (!op[0] && x[31]) ? -x : x;
            if (mag == 0) return 1;
            return 33 - lead_zeros(mag);
        end
`else
        return 33;
`endif
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard: expectation captured at accept, compared on every valid cycle
    logic        pend = 1'b0;
    logic        seen = 1'b0;
    logic [31:0] e_res;
    logic [4:0]  e_tag;
    logic        e_dbz;
    int          e_lat;
    int          acc;

    always @(negedge clk) begin
        if (rst || bus.flush) begin
            pend = 1'b0;
        end else begin
            if (bus.rsp_valid) begin
                if (!pend) chk("spurious_valid", bus.rsp_valid, 1'b0);
                else begin
                    chk("result", bus.result, e_res);
                    chk("tag", bus.rsp_tag, e_tag);
                    chk("dbz", bus.dbz, e_dbz);
                    chk("ready_in_done", bus.req_ready, 1'b0);
                    if (!seen) chk("latency", cyc - acc, e_lat);
                    seen = 1'b1;
                    if (bus.rsp_ready) pend = 1'b0;
                end
            end else if (pend) begin
                chk("ready_busy", bus.req_ready, 1'b0);
            end
            if (bus.req_valid && bus.req_ready) begin
                pend  = 1'b1;
                seen  = 1'b0;
                acc   = cyc;
                e_res = ref_res(bus.op, bus.rs1, bus.rs2);
                e_tag = bus.tag;
                e_dbz = bus.op[2] && bus.rs2 == 0;
                e_lat = ref_lat(bus.op, bus.rs1, bus.rs2);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t);
        int k = 0;
        while (k < 200 && !bus.req_ready) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.op        = muldiv_op_e'(op);
        bus.rs1       = x;
        bus.rs2       = y;
        bus.tag       = t;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rs1       = $urandom;
        bus.rs2       = $urandom;
    endtask

    task automatic wait_rsp(input int stall);
        int k = 0;
        while (k < 200 && !bus.rsp_valid) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rsp_wait", bus.rsp_valid, 1'b1);
        last_lat = k + 1;
        last_res = bus.result;
        last_tag = bus.rsp_tag;
        last_dbz = bus.dbz;
        for (int s = 0; s < stall; s++) begin
            bus.req_valid = 1'b1;
            bus.op        = muldiv_op_e'($urandom_range(0, 7));
            bus.rs1       = $urandom;
            bus.rs2       = $urandom;
            @(posedge clk); #1;
            chk("stall_ready", bus.req_ready, 1'b0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("ready_after_hs", bus.req_ready, 1'b1);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t, input int stall);
        send(op, x, y, t);
        wait_rsp(stall);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic any_valid;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        bus.op        = OP_MUL;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.tag       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_ready", bus.req_ready, 1'b1);
        chk("reset_valid", bus.rsp_valid, 1'b0);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_tag", bus.rsp_tag, 5'h0);
        chk("reset_dbz", bus.dbz, 1'b0);

        run(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 0);
        chk("mul_lit", last_res, 32'hFFFF_FFEB);
        chk("mul_tag_lit", last_tag, 5'd3);
        chk("mul_lat_lit", last_lat, 17);
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
        chk("mulh_lit", last_res, 32'h4000_0000);
        run(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd2, 0);
        chk("mulhsu_lit", last_res, 32'hFFFF_FFFF);

        run(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
        chk("div_lit", last_res, 32'hFFFF_FFFD);
        run(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 0);
        chk("rem_lit", last_res, 32'hFFFF_FFFF);
        run(3'd5, 32'd100, 32'd7, 5'd6, 0);
        chk("divu_lit", last_res, 32'd14);
`ifdef MULDIV_EARLY_OUT_EN
        chk("divu_lat_lit", last_lat, 8);
`else
        chk("divu_lat_lit", last_lat, 33);
`endif
        run(3'd7, 32'd100, 32'd7, 5'd7, 0);
        chk("remu_lit", last_res, 32'd2);

        run(3'd5, 32'd5, 32'd0, 5'd8, 0);
        chk("dbz_divu_lit", last_res, 32'hFFFF_FFFF);
        chk("dbz_flag_lit", last_dbz, 1'b1);
        chk("dbz_lat_lit", last_lat, 1);
        run(3'd7, 32'd5, 32'd0, 5'd9, 0);
        chk("dbz_remu_lit", last_res, 32'd5);
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        chk("ovf_div_lit", last_res, 32'h8000_0000);
        chk("ovf_lat_lit", last_lat, 1);
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        chk("ovf_rem_lit", last_res, 32'h0);

        run(3'd0, 32'd3, 32'd5, 5'd12, 5);
        chk("stall_lit", last_res, 32'd15);

        // flush mid-divide together with a new request in the same cycle
        send(3'd5, 32'd1000, 32'd7, 5'd13);
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.op        = OP_DIVU;
        bus.rs1       = 32'd50;
        bus.rs2       = 32'd5;
        bus.tag       = 5'd14;
        @(posedge clk); #1;
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        chk("flush_ready", bus.req_ready, 1'b1);
        any_valid = 1'b0;
        repeat (40) begin
            any_valid |= bus.rsp_valid;
            @(posedge clk); #1;
        end
        chk("flush_no_valid", any_valid, 1'b0);
        run(3'd5, 32'd9, 32'd3, 5'd15, 0);
        chk("post_flush_lit", last_res, 32'd3);

        // reset mid-multiply
        send(3'd0, 32'h1234, 32'h5678, 5'd21);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_ready", bus.req_ready, 1'b1);
        chk("rst_valid", bus.rsp_valid, 1'b0);
        chk("rst_result", bus.result, 32'h0);
        chk("rst_tag", bus.rsp_tag, 5'h0);
        chk("rst_dbz", bus.dbz, 1'b0);

        run(3'd5, 32'd3, 32'd1, 5'd16, 0);
        chk("divu31_lit", last_res, 32'd3);
`ifdef MULDIV_EARLY_OUT_EN
        chk("divu31_lat_lit", last_lat, 3);
`else
        chk("divu31_lat_lit", last_lat, 33);
`endif
        run(3'd5, 32'd0, 32'd5, 5'd17, 0);
        chk("divu05_lit", last_res, 32'd0);
`ifdef MULDIV_EARLY_OUT_EN
        chk("divu05_lat_lit", last_lat, 1);
`else
        chk("divu05_lat_lit", last_lat, 33);
`endif

        for (int i = 0; i < 200; i++)
            run(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), $urandom_range(0, 2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M/RV64M multiply/divide execution unit for the EX stage; replaces the free-running serial divider and combinational multiplier with one shared, handshaked, flushable block.
- Covers all eight M-extension ops, including the RISC-V divide-by-zero and signed-overflow results.
- Tags results so the pipeline can match them back to the issuing instruction.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- MUL_BITS, 2, multiplier bits retired per cycle (1, 2, 4 or 8; must divide XLEN).
- TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_flush  in  1  abort any in-flight op and drop any pending result.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (state IDLE).
- i_op  in  3  muldiv_op_e, encoding equals RISC-V funct3.
- i_rs1  in  XLEN  operand 1 (multiplicand/dividend).
- i_rs2  in  XLEN  operand 2 (multiplier/divisor).
- i_tag  in  TAG_W  request tag.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_result  out  XLEN  result.
- o_tag  out  TAG_W  tag of the result.
- o_dbz  out  1  result came from a divide by zero.

Behaviour:
- Reset: state=IDLE, o_ready=1, o_valid=0, o_result=0, o_tag=0, o_dbz=0, all internal registers 0.
- Accept: occurs on an i_clk edge with i_valid&&o_ready. Operands, op and tag are captured; absolute values are taken per signedness:
  - MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - Others: unsigned.
- FSM IDLE -> MUL | DIV | DONE; MUL -> DONE; DIV -> DONE; DONE -> IDLE on o_valid&&i_ready.
- Special cases (IDLE -> DONE directly, o_valid one cycle after accept):
  - Divisor 0: DIV/DIVU give all ones; REM/REMU give rs1; o_dbz=1.
  - DIV/REM with rs1=most negative and rs2=-1: DIV gives rs1; REM gives 0.
- MUL: shift-add over the 2*XLEN product, MUL_BITS bits per cycle, XLEN/MUL_BITS cycles in MUL.
  - If the operand signs differ, the 2*XLEN product is two's-complement negated on entry to DONE.
  - MUL returns bits [XLEN-1:0]; MULH/MULHSU/MULHU return bits [2*XLEN-1:XLEN].
  - Latency with default parameters is 17 cycles (accept edge to o_valid).
- DIV: restoring radix-2, one quotient bit per cycle, XLEN cycles in DIV.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - Latency is 33 cycles for XLEN=32.
- Down-counter: width $clog2(XLEN)+1. Loaded on accept; the state exits MUL/DIV when the counter reaches 1 and is decremented.
- DONE: o_valid=1. o_result, o_tag and o_dbz are held stable until the handshake. o_ready=0 in every state except IDLE.
- No result bypass: the next request is accepted at the earliest one cycle after the output handshake.
- i_flush priority: flush > output handshake > accept.
  - Next state is IDLE; o_valid=0 the next cycle.
  - An i_valid present in the flush cycle is not accepted.
  - A result in DONE is discarded.
- i_rst mid-operation: same effect as flush, plus o_result/o_tag/o_dbz are cleared.
- Outputs are registered, with no combinational path from i_valid/i_op to o_valid/o_result. o_ready depends only on state.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: on DIV/DIVU/REM/REMU accept, the dividend magnitude is pre-shifted by its leading-zero count L. The DIV state then iterates XLEN-L cycles.
  - A dividend of 0 goes IDLE -> DONE with quotient 0 and remainder 0.
- Undefined: DIV always takes XLEN cycles; no leading-zero logic is synthesised.
- Results are identical either way; only latency differs.

Decomposition:
- Package muldiv_pkg holds:
  - muldiv_op_e: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - muldiv_state_e: IDLE, MUL, DIV, DONE.
  - Helper functions is_div(op), rs1_signed(op), rs2_signed(op).
- Sub-module muldiv_lzc (parametrised XLEN, combinational leading-zero count). Instantiated only under MULDIV_EARLY_OUT_EN.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, tag=3 -> o_result=0xFFFFFFEB, o_tag=3, o_valid exactly 17 cycles after accept. MULH 0x80000000*0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF*2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2; latency 33 cycles (macro off).
- DIVU 5/0 -> 0xFFFFFFFF with o_dbz=1, REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each with o_valid 1 cycle after accept.
- Result in DONE with i_ready=0 for 5 cycles -> o_result/o_tag stable, o_ready=0, i_valid ignored; on i_ready=1 -> IDLE, o_ready=1 next cycle.
- i_flush at DIV iteration 10 with i_valid=1 in the same cycle -> no o_valid ever for either op, o_ready=1 next cycle; following DIVU 9/3 returns 3. Repeat with i_rst mid-MUL -> all outputs 0.
- MULDIV_EARLY_OUT_EN: DIVU 3/1 -> 3 with o_valid 3 cycles after accept; DIVU 0/5 -> 0 after 1 cycle; random ops -> results match the macro-off build bit-for-bit.
